// File: rtl/vblank_arb_pkg.sv
// Shared types and constants for the vblank write arbiter.
package vblank_arb_pkg;

  typedef enum logic [1:0] {
    WAIT_VBL = 2'd0,
    ARB      = 2'd1,
    BURST    = 2'd2
  } arb_state_e;

  localparam int FRAME_CNT_W = 16;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/vblank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  int              sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_write_arbiter.sv
// Grants a shared framebuffer write port only during vertical blanking; also frame tick/counter.
// Optional build macro VBLANK_ARB_OVERRUN_EN adds the sticky overrun flag and cut counter.
module vblank_write_arbiter
  import vblank_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 24,
  parameter int VER_FIELD   = 1023,
  parameter int VER_TOTAL   = 1065,
  parameter int GUARD_LINES = 2,
  parameter int MAX_BURST   = 64
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [10:0]               display_row_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      frame_tick_o,
  output logic [FRAME_CNT_W-1:0]    frame_count_o,
  output logic                      overrun_o
);

  localparam int                PTR_W     = $clog2(NUM_REQ);
  localparam int                BEAT_W    = $clog2(MAX_BURST + 1);
  localparam logic [10:0]       VIS_LAST  = 11'(VER_FIELD);
  localparam logic [10:0]       GUARD_ROW = 11'(VER_TOTAL - GUARD_LINES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  arb_state_e             state_q;
  logic                   vblank_q;
  logic                   vblank_prev_q;
  logic                   frame_tick_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [PTR_W-1:0]       win_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;
  logic [BEAT_W-1:0]      beat_cnt_q;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               beat_ok;
  logic               burst_end;
  logic               guard_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) pick_idx = PTR_W'(i);
    end
  end

  // Grant is cut the same cycle vblank_q falls so no write lands in active video.
  assign gnt       = gnt_q & {NUM_REQ{vblank_q}};
  assign beat_ok   = |(gnt & req_i);
  assign burst_end = beat_ok && (req_last_i[win_q] || beat_cnt_q == BEAT_LAST);
  assign guard_ok  = display_row_i <= GUARD_ROW;
  assign rr_ptr_d  = PTR_W'(wrap_inc(int'(win_q), NUM_REQ));

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr_o = mem_addr_o | req_addr_i[i*ADDR_W +: ADDR_W];
        mem_data_o = mem_data_o | req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt_o         = gnt;
  assign mem_we_o      = beat_ok;
  assign frame_tick_o  = frame_tick_q;
  assign frame_count_o = frame_count_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= WAIT_VBL;
      vblank_q      <= 1'b0;
      vblank_prev_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      gnt_q         <= '0;
      win_q         <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
    end else begin
      vblank_q      <= display_row_i > VIS_LAST;
      vblank_prev_q <= vblank_q;
      frame_tick_q  <= vblank_q & ~vblank_prev_q;
      if (vblank_q && !vblank_prev_q) frame_count_q <= frame_count_q + FRAME_CNT_W'(1);

      case (state_q)
        WAIT_VBL: begin
          if (vblank_q) state_q <= ARB;
        end
        ARB: begin
          if (!vblank_q) begin
            state_q <= WAIT_VBL;
          end else if (pick_valid && guard_ok) begin
            gnt_q      <= pick_win;
            win_q      <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (!vblank_q) begin
            gnt_q      <= '0;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= '0;
            state_q    <= WAIT_VBL;
          end else if (beat_ok) begin
            if (burst_end) begin
              gnt_q      <= '0;
              rr_ptr_q   <= rr_ptr_d;
              beat_cnt_q <= '0;
              state_q    <= ARB;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= WAIT_VBL;
      endcase
    end
  end

`ifdef VBLANK_ARB_OVERRUN_EN
  logic       cut;
  logic       overrun_q;
  logic [7:0] cut_cnt_q;

  assign cut = (state_q == BURST) && !vblank_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overrun_q <= 1'b0;
      cut_cnt_q <= '0;
    end else if (cut) begin
      overrun_q <= 1'b1;
      if (cut_cnt_q != 8'hFF) cut_cnt_q <= cut_cnt_q + 8'd1;
    end
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, randomized run vs. reference model.
module tb_vblank_write_arbiter;
  import vblank_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   row;
  logic [N-1:0]  req, last;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic [N-1:0]  gnt;
  logic          we;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic          tick;
  logic [15:0]   fcnt;
  logic          ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vblank_write_arbiter dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .display_row_i (row),
    .req_i         (req),
    .req_last_i    (last),
    .req_addr_i    (addr),
    .req_data_i    (data),
    .gnt_o         (gnt),
    .mem_we_o      (we),
    .mem_addr_o    (maddr),
    .mem_data_o    (mdata),
    .frame_tick_o  (tick),
    .frame_count_o (fcnt),
    .overrun_o     (ovr)
  );

  typedef struct {
    int          hold;
    logic [10:0] row;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic        we;
    logic        tick;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return addr[i*AW +: AW];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return data[i*DW +: DW];
    return '0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference model state
  int          m_owner, m_beats, m_ptr, m_sel;
  bit          m_armed, m_vb, m_vbp, m_tick, m_ov, m_nt;
  logic [15:0] m_cnt;
  logic [N-1:0] e_g;
  logic        e_ov;

  initial begin
    logic [3:0] g;
    int beats, lat;

    row = 11'd500; req = '0; last = '0;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'(32'h1000 + i);
      data[i*DW +: DW] = DW'(32'hA00000 + i);
    end

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_state", 64'(dut.state_q), 64'(WAIT_VBL));
    rst_n = 1'b1;

    // active video lockout, vblank entry, round-robin 3-beat bursts
    tbl.push_back('{20, 11'd500, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1, 11'd1024, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1, 11'd1024, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1, 11'd1024, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd1});
    for (int r = 0; r < 5; r++) begin
      g = 4'(1 << (r % 4));
      tbl.push_back('{2, 11'd1024, 4'b1111, 4'b0000, g, 1'b1, 1'b0, 16'd1});
      tbl.push_back('{1, 11'd1024, 4'b1111, 4'b1111, g, 1'b1, 1'b0, 16'd1});
      tbl.push_back('{1, 11'd1024, (r == 4) ? 4'b0100 : 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd1});
    end
    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].hold; c++) begin
        @(negedge clk);
        row = tbl[k].row; req = tbl[k].req; last = tbl[k].last;
        #1;
        chk($sformatf("v%0d_gnt", k), gnt, tbl[k].gnt);
        chk($sformatf("v%0d_we", k), we, tbl[k].we);
        chk($sformatf("v%0d_tick", k), tick, tbl[k].tick);
        chk($sformatf("v%0d_cnt", k), fcnt, tbl[k].cnt);
        chk($sformatf("v%0d_addr", k), maddr, exp_addr(tbl[k].gnt));
        chk($sformatf("v%0d_data", k), mdata, exp_data(tbl[k].gnt));
      end
    end

    // requester 2 streams without req_last: cut at MAX_BURST
    @(negedge clk);
    row = 11'd1024; req = 4'b0100; last = '0;
    #1;
    chk("t3_start", gnt, 4'b0100);
    beats = 0;
    for (int c = 0; c < 100 && gnt == 4'b0100; c++) begin
      if (we) beats++;
      @(negedge clk);
      #1;
    end
    chk("t3_beats", beats, 64);
    chk("t3_drop", gnt, 0);
    req = 4'b1111;
    @(negedge clk);
    last = 4'b1000;
    #1;
    chk("t3_next", gnt, 4'b1000);
    @(negedge clk);
    req = '0; last = '0;
    #1;
    chk("t3_end", gnt, 0);

    // vblank ends mid-burst
    @(negedge clk);
    row = 11'd1024; req = 4'b0001;
    @(negedge clk);
    row = 11'd1065;
    #1;
    chk("t4_gnt_a", gnt, 4'b0001);
    chk("t4_we_a", we, 1);
    @(negedge clk);
    row = 11'd0;
    #1;
    chk("t4_gnt_b", gnt, 4'b0001);
    @(negedge clk);
    #1;
    chk("t4_cut_gnt", gnt, 0);
    chk("t4_cut_we", we, 0);
    chk("t4_cut_addr", maddr, 0);
    @(negedge clk);
    #1;
    chk("t4_state", 64'(dut.state_q), 64'(WAIT_VBL));
`ifdef VBLANK_ARB_OVERRUN_EN
    chk("t4_ovr", ovr, 1);
`else
    chk("t4_ovr", ovr, 0);
`endif

    // guard window blocks a new burst at row 1064
    @(negedge clk);
    row = 11'd1064; req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("t5_guard_gnt", gnt, 0);
    end
    chk("t5_cnt", fcnt, 2);
    req = '0; row = 11'd0;
    repeat (3) @(negedge clk);
    row = 11'd1030; req = 4'b0010;
    lat = 0;
    #1;
    while (gnt == 0 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("t5_gnt", gnt, 4'b0010);
    chk("t5_lat", lat, 3);
    chk("t5_cnt2", fcnt, 3);

    // reset asserted on beat 10
    repeat (9) @(negedge clk);
    chk("t6_beat", dut.beat_cnt_q, 9);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", gnt, 0);
    chk("t6_we", we, 0);
    chk("t6_addr", maddr, 0);
    chk("t6_data", mdata, 0);
    chk("t6_tick", tick, 0);
    chk("t6_cnt", fcnt, 0);
    chk("t6_ovr", ovr, 0);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    #1;
    while (gnt == 0 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("t6_fresh_gnt", gnt, 4'b0001);
    chk("t6_fresh_cnt", fcnt, 1);

    // randomized run against the reference model
    @(negedge clk);
    rst_n = 1'b0; row = '0; req = '0; last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_beats = 0; m_ptr = 0; m_armed = 0; m_vb = 0; m_vbp = 0;
    m_tick = 0; m_ov = 0; m_cnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (row >= 11'd1065) row = '0;
      else if (row < 11'd1000) row = row + 11'd50;
      else row = row + 11'd1;
      req  = N'($urandom);
      last = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = AW'($urandom);
        data[i*DW +: DW] = DW'($urandom);
      end
      #1;
      e_g = (m_owner >= 0 && m_vb) ? N'(1 << m_owner) : '0;
`ifdef VBLANK_ARB_OVERRUN_EN
      e_ov = m_ov;
`else
      e_ov = 1'b0;
`endif
      chk($sformatf("rand%0d", cyc), {1'b0, gnt, we, maddr, mdata, tick, fcnt, ovr},
          {1'b0, e_g, |(e_g & req), exp_addr(e_g), exp_data(e_g), m_tick, m_cnt, e_ov});

      m_nt = m_vb && !m_vbp;
      if (!m_armed) begin
        m_armed = m_vb;
      end else if (m_owner < 0) begin
        if (!m_vb) m_armed = 0;
        else if (req != 0 && row <= 11'd1063) begin
          m_sel = -1;
          for (int k = 0; k < N; k++)
            if (m_sel < 0 && req[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
          m_owner = m_sel;
          m_beats = 0;
        end
      end else if (!m_vb) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_armed = 0; m_ov = 1;
      end else if (req[m_owner]) begin
        m_beats++;
        if (last[m_owner] || m_beats == 64) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end
      m_vbp = m_vb;
      m_vb = (row > 11'd1023);
      m_tick = m_nt;
      if (m_nt) m_cnt = m_cnt + 16'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
